ls_unit_gen: RTL and testbench

Parametrised load/store unit: accepts one memory request at a time from the execute stage, turns it into a Wishbone-style bus cycle on the `i*` data bus (same bus `bram` serves), and returns aligned, sign- or zero-extended load data. It generalises the existing load_store_unit to XLEN 32 or 64 with true byte selects. It adds misalignment and illegal-size detection, bus-error reporting and a bus timeout.

---
 rtl/ls_unit_gen.sv | 258 +++++++++++++++++++++++++
 tb/tb_ls_unit_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_unit_gen.sv
// Load/store unit: takes one execute-stage memory request at a time and runs
// it as a single Wishbone-style bus cycle. Loads come back aligned and
// extended. Misaligned or illegal accesses are answered without touching the
// bus. Bus errors and an optional cycle timeout are reported through rsp_cause.
module ls_unit_gen #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,

    // request from execute stage
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,

    // response to execute stage
    output logic                  rsp_valid,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic [1:0]            rsp_cause,
    output logic                  busy,

    // data bus master
    output logic [ADDR_WIDTH-1:0] iaddr_o,
    output logic [XLEN-1:0]       idat_o,
    output logic [XLEN/8-1:0]     isel_o,
    output logic                  icyc_o,
    output logic                  istb_o,
    output logic                  iwe_o,
    input  logic [XLEN-1:0]       idat_i,
    input  logic                  iack_i,
    input  logic                  ierr_i
);

    localparam int SW = XLEN / 8;
    localparam int OW = $clog2(SW);
    // a zero-width counter is not legal, so keep one bit when the timeout is off
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] CAUSE_OK    = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BERR  = 2'b10;
    localparam logic [1:0] CAUSE_TMO   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    icyc_q, icyc_d;
    logic                    iwe_q, iwe_d;
    logic [SW-1:0]           isel_q, isel_d;
    logic [ADDR_WIDTH-1:0]   iaddr_q, iaddr_d;
    logic [XLEN-1:0]         idat_q, idat_d;
    logic [XLEN-1:0]         rdata_q, rdata_d;
    logic [1:0]              cause_q, cause_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              f3_q, f3_d;
    logic [OW-1:0]           off_q, off_d;

    // request decode
    logic                    size_illegal;
    logic                    misaligned;
    logic [OW-1:0]           req_off;
    logic [SW-1:0]           size_mask;
    logic [SW-1:0]           req_sel;
    logic [XLEN-1:0]         req_wlane;

    // load return path
    logic [XLEN-1:0]         lane_shifted;
    logic [31:0]             ld_width;
    logic                    ld_sign;
    logic                    ld_fill;
    logic [XLEN-1:0]         ld_ext;

    logic                    tmo_hit;

    assign req_off = req_addr[OW-1:0];

    // classify the request: illegal size codes and addresses not aligned to the size
    always_comb begin
        size_illegal = 1'b0;
        if (req_funct3 == 3'b111) begin
            size_illegal = 1'b1;
        end
        if ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110))) begin
            size_illegal = 1'b1;
        end
        // unsigned size codes only make sense for loads
        if (req_we && req_funct3[2]) begin
            size_illegal = 1'b1;
        end

        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase

        size_mask = '0;
        case (req_funct3[1:0])
            2'd0:    size_mask = SW'(1);
            2'd1:    size_mask = SW'(3);
            2'd2:    size_mask = SW'(15);
            default: size_mask = '1;
        endcase
    end

    assign req_sel = size_mask << req_off;

    // each lane carries the store byte that lands there once the low size bytes are replicated
    for (genvar gi = 0; gi < SW; gi++) begin : g_lane
        assign req_wlane[gi*8 +: 8] =
            (req_funct3[1:0] == 2'd0) ? req_wdata[7:0] :
            (req_funct3[1:0] == 2'd1) ? req_wdata[(gi % 2)*8 +: 8] :
            (req_funct3[1:0] == 2'd2) ? req_wdata[(gi % 4)*8 +: 8] :
                                        req_wdata[gi*8 +: 8];
    end

    // bring the addressed bytes down to bit 0 and pick the sign bit for the access size
    always_comb begin
        lane_shifted = idat_i >> {off_q, 3'b000};
        ld_width     = 32'd8 << f3_q[1:0];
        case (f3_q[1:0])
            2'd0:    ld_sign = lane_shifted[7];
            2'd1:    ld_sign = lane_shifted[15];
            2'd2:    ld_sign = lane_shifted[31];
            default: ld_sign = lane_shifted[XLEN-1];
        endcase
        // BU/HU/WU and D fill with zeros above the access width
        ld_fill = ld_sign & ~f3_q[2] & (f3_q[1:0] != 2'd3);
    end

    for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
        assign ld_ext[gi] = (gi < ld_width) ? lane_shifted[gi] : ld_fill;
    end

    // timeout fires on the edge that closes the TIMEOUT-th bus cycle
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    // next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        icyc_d  = icyc_q;
        iwe_d   = iwe_q;
        isel_d  = isel_q;
        iaddr_d = iaddr_q;
        idat_d  = idat_q;
        rdata_d = rdata_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (size_illegal || misaligned) begin
                        state_d = S_RESP;
                        cause_d = CAUSE_ALIGN;
                        rdata_d = '0;
                    end else begin
                        state_d = S_BUS;
                        icyc_d  = 1'b1;
                        iwe_d   = req_we;
                        isel_d  = req_sel;
                        iaddr_d = {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
                        idat_d  = req_wlane;
                        f3_d    = req_funct3;
                        off_d   = req_off;
                        cnt_d   = '0;
                    end
                end
            end

            S_BUS: begin
                if (ierr_i || iack_i || tmo_hit) begin
                    state_d = S_RESP;
                    icyc_d  = 1'b0;
                    iwe_d   = 1'b0;
                    isel_d  = '0;
                    rdata_d = '0;
                    if (ierr_i) begin
                        cause_d = CAUSE_BERR;
                    end else if (iack_i) begin
                        cause_d = CAUSE_OK;
                        if (!iwe_q) begin
                            rdata_d = ld_ext;
                        end
                    end else begin
                        cause_d = CAUSE_TMO;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and bus/response registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            icyc_q  <= 1'b0;
            iwe_q   <= 1'b0;
            isel_q  <= '0;
            iaddr_q <= '0;
            idat_q  <= '0;
            rdata_q <= '0;
            cause_q <= CAUSE_OK;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            icyc_q  <= icyc_d;
            iwe_q   <= iwe_d;
            isel_q  <= isel_d;
            iaddr_q <= iaddr_d;
            idat_q  <= idat_d;
            rdata_q <= rdata_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_cause = cause_q;

    assign iaddr_o = iaddr_q;
    assign idat_o  = idat_q;
    assign isel_o  = isel_q;
    assign icyc_o  = icyc_q;
    assign istb_o  = icyc_q;
    assign iwe_o   = iwe_q;

endmodule

// File: tb/tb_ls_unit_gen.sv
// Bench for ls_unit_gen: one 32-bit instance (TIMEOUT=8) and one 64-bit
// instance (timeout disabled) share the request and bus-slave stimulus; only
// the addressed instance sees req_valid. Directed cases plus random requests
// are compared with a byte-level reference model.
module tb_ls_unit_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v32 = 1'b0;
    logic        v64 = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [63:0] bus_rdata = '0;
    logic        iack = 1'b0;
    logic        ierr = 1'b0;

    logic        rdy32, rv32, busy32, cyc32, stb32, we32;
    logic [31:0] rd32, ia32, id32;
    logic [1:0]  c32;
    logic [3:0]  is32;

    logic        rdy64, rv64, busy64, cyc64, stb64, we64;
    logic [63:0] rd64, id64;
    logic [31:0] ia64;
    logic [1:0]  c64;
    logic [7:0]  is64;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ls_unit_gen #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(8)) u32 (
        .clk(clk), .rst(rst),
        .req_valid(v32), .req_ready(rdy32), .req_we(req_we), .req_funct3(f3),
        .req_addr(addr), .req_wdata(wdata[31:0]),
        .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_cause(c32), .busy(busy32),
        .iaddr_o(ia32), .idat_o(id32), .isel_o(is32), .icyc_o(cyc32), .istb_o(stb32),
        .iwe_o(we32), .idat_i(bus_rdata[31:0]), .iack_i(iack), .ierr_i(ierr)
    );

    ls_unit_gen #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT(0)) u64 (
        .clk(clk), .rst(rst),
        .req_valid(v64), .req_ready(rdy64), .req_we(req_we), .req_funct3(f3),
        .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(rv64), .rsp_rdata(rd64), .rsp_cause(c64), .busy(busy64),
        .iaddr_o(ia64), .idat_o(id64), .isel_o(is64), .icyc_o(cyc64), .istb_o(stb64),
        .iwe_o(we64), .idat_i(bus_rdata), .iack_i(iack), .ierr_i(ierr)
    );

    // view of whichever instance is under test
    logic        use64 = 1'b0;
    logic        o_ready, o_rv, o_busy, o_cyc, o_stb, o_we;
    logic [63:0] o_rd, o_dat;
    logic [31:0] o_addr;
    logic [1:0]  o_cause;
    logic [7:0]  o_sel;

    always_comb begin
        if (use64) begin
            o_ready = rdy64; o_rv = rv64; o_busy = busy64; o_cyc = cyc64;
            o_stb = stb64; o_we = we64; o_rd = rd64; o_dat = id64;
            o_addr = ia64; o_cause = c64; o_sel = is64;
        end else begin
            o_ready = rdy32; o_rv = rv32; o_busy = busy32; o_cyc = cyc32;
            o_stb = stb32; o_we = we32; o_rd = {32'd0, rd32}; o_dat = {32'd0, id32};
            o_addr = ia32; o_cause = c32; o_sel = {4'd0, is32};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    // Reference model: what the bus should see and what a load returns,
    // derived byte by byte from the request.
    task automatic model(input bit x64, input bit we, input logic [2:0] fc,
                         input logic [31:0] a, input logic [63:0] wd, input logic [63:0] bd,
                         output bit bad, output logic [63:0] sel, output logic [63:0] dat,
                         output logic [63:0] ld);
        int nb, sw, off;
        logic [127:0] raw, m;
        logic [63:0] bdx;
        nb  = 1 << fc[1:0];
        sw  = x64 ? 8 : 4;
        bad = (fc == 3'd7) || (!x64 && (fc == 3'd3 || fc == 3'd6)) || (we && fc[2])
              || ((a % nb) != 0);
        off = int'(a % sw);
        sel = 64'(((1 << nb) - 1) << off);
        dat = '0;
        for (int i = 0; i < sw; i++)
            dat = dat | (((wd >> (8 * (i % nb))) & 64'hff) << (8 * i));
        bdx = x64 ? bd : (bd & 64'hffff_ffff);
        raw = 128'(bdx) >> (8 * off);
        m   = (128'd1 << (8 * nb)) - 128'd1;
        raw = raw & m;
        if (!fc[2] && fc != 3'd3 && raw[8*nb-1]) raw = raw | ~m;
        ld  = raw[63:0];
        if (!x64) ld = ld & 64'hffff_ffff;
    endtask

    // One request through the addressed instance. waits = bus cycles before
    // the slave answers; never_ack lets the timeout end the cycle.
    task automatic xact(input bit x64, input bit we, input logic [2:0] fc,
                        input logic [31:0] a, input logic [63:0] wd, input logic [63:0] bd,
                        input int waits, input bit err, input bit ack_too, input bit never_ack);
        bit bad;
        logic [63:0] e_sel, e_dat, e_ld, e_rd;
        logic [1:0]  e_cause;
        int ncyc;
        model(x64, we, fc, a, wd, bd, bad, e_sel, e_dat, e_ld);
        use64 = x64;
        @(negedge clk);
        chk("ready_idle", o_ready, 1);
        req_we = we; f3 = fc; addr = a; wdata = wd;
        if (x64) v64 = 1'b1; else v32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0; v64 = 1'b0;
        if (bad) begin
            e_cause = 2'b01;
            e_rd    = '0;
            chk("align_cyc", o_cyc, 0);
        end else begin
            chk("bus_cyc", o_cyc, 1);
            chk("bus_stb", o_stb, 1);
            chk("bus_we", o_we, we);
            chk("bus_sel", o_sel, e_sel);
            chk("bus_addr", o_addr, a & ~32'(x64 ? 7 : 3));
            chk("bus_dat", o_dat, e_dat);
            chk("bus_ready", o_ready, 0);
            chk("bus_busy", o_busy, 1);
            ncyc = 0;
            if (never_ack) begin
                while (o_cyc && ncyc < 300) begin
                    ncyc++;
                    @(negedge clk);
                end
                chk("tmo_len", 64'(ncyc), 64'd8);
                e_cause = 2'b11;
                e_rd    = '0;
            end else begin
                for (int i = 0; i < waits; i++) begin
                    if (o_cyc) ncyc++;
                    @(negedge clk);
                end
                if (o_cyc) ncyc++;
                bus_rdata = bd;
                ierr = err;
                iack = !err || ack_too;
                @(negedge clk);
                iack = 1'b0; ierr = 1'b0;
                chk("cyc_len", 64'(ncyc), 64'(waits + 1));
                e_cause = err ? 2'b10 : 2'b00;
                e_rd    = (err || we) ? 64'd0 : e_ld;
            end
            chk("rsp_sel", o_sel, 0);
        end
        chk("rsp_valid", o_rv, 1);
        chk("rsp_cause", o_cause, e_cause);
        chk("rsp_rdata", o_rd, e_rd);
        chk("rsp_cyc", o_cyc, 0);
        @(negedge clk);
        chk("post_valid", o_rv, 0);
        chk("post_rdata", o_rd, e_rd);
        chk("post_ready", o_ready, 1);
        $display("xact x%0d we=%0d f3=%0d addr=%h wd=%h cause=%0d rdata=%h",
                 x64 ? 64 : 32, we, fc, a, wd, o_cause, o_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rx, rwe, rerr, rack;
        logic [2:0] rf;
        logic [31:0] ra;
        int seen;

        // reset values on both instances
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            use64 = (k == 1);
            #1;
            chk("rst_cyc", o_cyc, 0);
            chk("rst_stb", o_stb, 0);
            chk("rst_we", o_we, 0);
            chk("rst_sel", o_sel, 0);
            chk("rst_addr", o_addr, 0);
            chk("rst_dat", o_dat, 0);
            chk("rst_valid", o_rv, 0);
            chk("rst_rdata", o_rd, 0);
            chk("rst_cause", o_cause, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_ready", o_ready, 1);
        end
        @(negedge clk);
        rst = 1'b1;

        // XLEN=32 directed
        xact(0, 1, 3'd2, 32'h10, 64'hDEADBEEF, 64'h0, 2, 0, 0, 0);
        xact(0, 1, 3'd0, 32'h13, 64'hA5, 64'h0, 0, 0, 0, 0);
        xact(0, 0, 3'd0, 32'h13, 64'h0, 64'hA5000000, 1, 0, 0, 0);
        xact(0, 0, 3'd4, 32'h13, 64'h0, 64'hA5000000, 0, 0, 0, 0);
        xact(0, 0, 3'd1, 32'h12, 64'h0, 64'h80011234, 0, 0, 0, 0);
        xact(0, 0, 3'd2, 32'h12, 64'h0, 64'h0, 0, 0, 0, 0);
        xact(0, 0, 3'd3, 32'h08, 64'h0, 64'h0, 0, 0, 0, 0);
        xact(0, 0, 3'd2, 32'h20, 64'h0, 64'h12345678, 1, 1, 1, 0);
        xact(0, 1, 3'd1, 32'h22, 64'hBEEF, 64'h0, 0, 1, 0, 0);
        xact(0, 0, 3'd2, 32'h40, 64'h0, 64'h0, 0, 0, 0, 1);

        // stray acknowledge while idle
        use64 = 1'b0;
        @(negedge clk);
        iack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stray_valid", o_rv, 0);
        chk("stray_cyc", o_cyc, 0);
        chk("stray_ready", o_ready, 1);
        iack = 1'b0;

        // XLEN=64 directed
        xact(1, 0, 3'd2, 32'h0C, 64'h0, 64'h80000000_00000000, 0, 0, 0, 0);
        xact(1, 0, 3'd3, 32'h08, 64'h0, 64'hFEDCBA98_76543210, 1, 0, 0, 0);
        xact(1, 1, 3'd3, 32'h18, 64'h01234567_89ABCDEF, 64'h0, 0, 0, 0, 0);
        xact(1, 0, 3'd6, 32'h0C, 64'h0, 64'h80000000_00000000, 0, 0, 0, 0);
        xact(1, 0, 3'd3, 32'h30, 64'h0, 64'h55AA55AA_0F0F0F0F, 99, 0, 0, 0);

        // reset in the middle of a 64-bit bus cycle
        use64 = 1'b1;
        @(negedge clk);
        req_we = 1'b0; f3 = 3'd3; addr = 32'h08; v64 = 1'b1;
        @(negedge clk);
        v64 = 1'b0;
        chk("mid_cyc_before", o_cyc, 1);
        rst = 1'b0;
        #1;
        chk("mid_cyc_async", o_cyc, 0);
        chk("mid_stb_async", o_stb, 0);
        @(negedge clk);
        rst = 1'b1;
        iack = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_rv) seen++;
        end
        iack = 1'b0;
        chk("mid_no_rsp", 64'(seen), 64'd0);
        chk("mid_ready", o_ready, 1);

        // random requests on both widths
        for (int n = 0; n < 60; n++) begin
            rx   = n[0];
            rwe  = 1'($urandom_range(0, 1));
            rf   = rwe ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            ra   = $urandom & 32'hFF;
            if ($urandom_range(0, 3) != 0) ra = ra & ~((32'd1 << rf[1:0]) - 32'd1);
            rerr = ($urandom_range(0, 7) == 0);
            rack = 1'($urandom_range(0, 1));
            xact(rx, rwe, rf, ra, {$urandom, $urandom}, {$urandom, $urandom},
                 int'($urandom_range(0, 3)), rerr, rack, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
